box_fill_engine: RTL and testbench

Parametrised rectangle writer for the VGA frame-buffer path and the next generation of the star-cleaning block. It fills or outlines an axis-aligned box with a programmable colour, emitting one pixel write per accepted handshake. Each write carries the linear memory address, the pixel coordinates and the colour. It sits between the star-detection control FSM and the frame-buffer write arbiter, and honours arbiter backpressure through `wrReady`.

---
 rtl/box_fill_engine.sv | 162 ++++++++++++++++
 tb/tb_box_fill_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/box_fill_engine.sv
// Purpose : fills or outlines an axis-aligned box, one pixel write per accepted handshake.
// Latency : first write one cycle after start; N pixels take N cycles plus stalls, then a done cycle.
// Backpr. : wrEn holds x/y/addr/colour stable until wrReady; every stalled cycle adds one cycle.
// Ports   : clk, resetn (sync, active-low); start + xLeft/xRight/yTop/yBottom/colIn/mode request;
//           wrReady in; wrEn/xOut/yOut/addrOut/colOut write; busy, done, err status.
module box_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COL_W    = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [X_W-1:0]    xLeft,
  input  logic [X_W-1:0]    xRight,
  input  logic [Y_W-1:0]    yTop,
  input  logic [Y_W-1:0]    yBottom,
  input  logic [COL_W-1:0]  colIn,
  input  logic              mode,
  input  logic              wrReady,
  output logic              wrEn,
  output logic [X_W-1:0]    xOut,
  output logic [Y_W-1:0]    yOut,
  output logic [ADDR_W-1:0] addrOut,
  output logic [COL_W-1:0]  colOut,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One spare bit so the product never wraps before truncation.
  localparam int AW = ADDR_W + 1;
  localparam logic [X_W:0]    SCREEN_W_X = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]    SCREEN_H_Y = (Y_W + 1)'(SCREEN_H);
  localparam logic [AW-1:0]   SCREEN_W_A = AW'(SCREEN_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [X_W-1:0]   xL, xR, xCur, xNext;
  logic [Y_W-1:0]   yT, yB, yCur, yNext;
  logic [COL_W-1:0] colR;
  logic             modeR;
  logic             errR, errNext;
  logic             load;
  logic             badBox;
  logic [AW-1:0]    addrWide;

  // Bounds are checked on the raw inputs in the start cycle, so the
  // counters can never step past the screen edge.
  assign badBox = (xLeft > xRight) || (yTop > yBottom) ||
                  ({1'b0, xRight} >= SCREEN_W_X) ||
                  ({1'b0, yBottom} >= SCREEN_H_Y);

  assign addrWide = AW'(yCur) * SCREEN_W_A + AW'(xCur);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    xNext     = xCur;
    yNext     = yCur;
    errNext   = errR;
    load      = 1'b0;
    wrEn      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    colOut    = '0;
    xOut      = xCur;
    yOut      = yCur;
    addrOut   = addrWide[ADDR_W-1:0];

    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (badBox) begin
            stateNext = DONE;
            errNext   = 1'b1;
          end else begin
            stateNext = WRITE;
            errNext   = 1'b0;
            xNext     = xLeft;
            yNext     = yTop;
          end
        end
      end

      WRITE: begin
        wrEn   = 1'b1;
        busy   = 1'b1;
        colOut = colR;
        if (wrReady) begin
          if (xCur == xR && yCur == yB) begin
            stateNext = DONE;
          end else if (xCur == xR) begin
            yNext = yCur + Y_W'(1);
            xNext = xL;
          end else if (modeR && yCur != yT && yCur != yB && xCur == xL) begin
            // Outline interior row: jump straight to the right edge.
            xNext = xR;
          end else begin
            xNext = xCur + X_W'(1);
          end
        end
      end

      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        err       = errR;
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      xCur  <= '0;
      yCur  <= '0;
      errR  <= 1'b0;
      xL    <= '0;
      xR    <= '0;
      yT    <= '0;
      yB    <= '0;
      colR  <= '0;
      modeR <= 1'b0;
    end else begin
      xCur <= xNext;
      yCur <= yNext;
      errR <= errNext;
      if (load) begin
        xL    <= xLeft;
        xR    <= xRight;
        yT    <= yTop;
        yB    <= yBottom;
        colR  <= colIn;
        modeR <= mode;
      end
    end
  end

endmodule

// File: tb/tb_box_fill_engine.sv
// Purpose : self-checking bench for box_fill_engine against a pixel-list model.
// Latency : model expects writes from cycle 1, done right after the last accepted write.
// Backpr. : wrReady driven always-high, alternating, or random per box.
module tb_box_fill_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  xLeft, xRight;
  logic [6:0]  yTop, yBottom;
  logic [2:0]  colIn;
  logic        mode;
  logic        wrReady;
  logic        wrEn;
  logic [7:0]  xOut;
  logic [6:0]  yOut;
  logic [14:0] addrOut;
  logic [2:0]  colOut;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  box_fill_engine dut (
    .clk(clk), .resetn(resetn), .start(start),
    .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom),
    .colIn(colIn), .mode(mode), .wrReady(wrReady),
    .wrEn(wrEn), .xOut(xOut), .yOut(yOut), .addrOut(addrOut), .colOut(colOut),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Runs one box. Model: the list of pixels in raster order that belong to the
  // box (all of them for fill, only edge pixels for outline). Each cycle the
  // DUT must present the list head until the bench's wrReady accepts it, then
  // show done for one cycle, then go idle.
  // rm: 0 ready always, 1 ready on odd cycles, 2 random.
  // pulse: 0 none, 1 start in cycle 2, 2 start in the done cycle (rm 0 only).
  task automatic runBox(input logic [7:0] xl, input logic [7:0] xr,
                        input logic [6:0] yt, input logic [6:0] yb,
                        input logic [2:0] col, input logic md,
                        input int rm, input int pulse,
                        output int nW, output int doneAt,
                        output int firstA, output int lastA);
    int  qx[$];
    int  qy[$];
    bit  expErr;
    bit  doneSeen;
    bit  fin;
    expErr = (xl > xr) || (yt > yb) || (int'(xr) >= 160) || (int'(yb) >= 120);
    if (!expErr) begin
      for (int y = int'(yt); y <= int'(yb); y++)
        for (int x = int'(xl); x <= int'(xr); x++)
          if (!md || y == int'(yt) || y == int'(yb) || x == int'(xl) || x == int'(xr)) begin
            qx.push_back(x);
            qy.push_back(y);
          end
    end
    nW     = qx.size();
    firstA = (nW > 0) ? qy[0] * 160 + qx[0] : -1;
    lastA  = (nW > 0) ? qy[nW-1] * 160 + qx[nW-1] : -1;

    @(posedge clk); #1;
    xLeft = xl; xRight = xr; yTop = yt; yBottom = yb; colIn = col; mode = md;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble request inputs: the DUT must work from its latched copy.
    xLeft = 8'($urandom); xRight = 8'($urandom);
    yTop = 7'($urandom); yBottom = 7'($urandom);
    colIn = 3'($urandom); mode = 1'($urandom);

    doneSeen = 0;
    fin      = 0;
    doneAt   = -1;
    for (int c = 1; c <= 500; c++) begin
      case (rm)
        0:       wrReady = 1'b1;
        1:       wrReady = (c % 2 == 1);
        default: wrReady = 1'($urandom_range(0, 1));
      endcase
      start = (pulse == 1 && c == 2) || (pulse == 2 && c == nW + 1);
      @(negedge clk);
      if (qx.size() > 0) begin
        chk("wrEn", wrEn, 1);
        chk("busyWrite", busy, 1);
        chk("doneWrite", done, 0);
        chk("xOut", xOut, qx[0]);
        chk("yOut", yOut, qy[0]);
        chk("addrOut", addrOut, qy[0] * 160 + qx[0]);
        chk("colOut", colOut, col);
        if (wrReady) begin
          void'(qx.pop_front());
          void'(qy.pop_front());
        end
      end else if (!doneSeen) begin
        chk("done", done, 1);
        chk("err", err, expErr);
        chk("wrEnDone", wrEn, 0);
        chk("busyDone", busy, 1);
        chk("colOutDone", colOut, 0);
        doneSeen = 1;
        doneAt   = c;
      end else begin
        chk("busyIdle", busy, 0);
        chk("doneIdle", done, 0);
        chk("wrEnIdle", wrEn, 0);
        fin = 1;
      end
      @(posedge clk); #1;
      if (fin) break;
    end
    start   = 1'b0;
    wrReady = 1'b1;
    chk("boxCompletes", fin, 1);
  endtask

  initial begin
    int nW, doneAt, fA, lA;
    int a, b;
    logic [7:0] rxl, rxr;
    logic [6:0] ryt, ryb;

    resetn = 1'b0; start = 1'b0; wrReady = 1'b1; mode = 1'b0;
    xLeft = '0; xRight = '0; yTop = '0; yBottom = '0; colIn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstWrEn", wrEn, 0);   chk("rstBusy", busy, 0);
    chk("rstDone", done, 0);   chk("rstErr", err, 0);
    chk("rstX", xOut, 0);      chk("rstY", yOut, 0);
    chk("rstAddr", addrOut, 0); chk("rstCol", colOut, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Fill 4x3 box.
    runBox(8'd10, 8'd13, 7'd20, 7'd22, 3'd5, 1'b0, 0, 0, nW, doneAt, fA, lA);
    chk("fillCount", nW, 12);  chk("fillFirstAddr", fA, 3210);
    chk("fillLastAddr", lA, 3533); chk("fillDoneCycle", doneAt, 13);

    // Outline of the same box, with a stray start during WRITE.
    runBox(8'd10, 8'd13, 7'd20, 7'd22, 3'd5, 1'b1, 0, 1, nW, doneAt, fA, lA);
    chk("outlineCount", nW, 10); chk("outlineDoneCycle", doneAt, 11);

    // 2x2 fill under alternating backpressure.
    runBox(8'd3, 8'd4, 7'd7, 7'd8, 3'd2, 1'b0, 1, 0, nW, doneAt, fA, lA);
    chk("bpCount", nW, 4); chk("bpDoneCycle", doneAt, 8);

    // Rejections.
    runBox(8'd20, 8'd10, 7'd5, 7'd6, 3'd1, 1'b0, 0, 0, nW, doneAt, fA, lA);
    chk("rejXCount", nW, 0); chk("rejXDoneCycle", doneAt, 1);
    runBox(8'd0, 8'd3, 7'd100, 7'd120, 3'd1, 1'b0, 0, 0, nW, doneAt, fA, lA);
    chk("rejYCount", nW, 0); chk("rejYDoneCycle", doneAt, 1);

    // Bottom-right pixel, start pulsed in the done cycle.
    runBox(8'd159, 8'd159, 7'd119, 7'd119, 3'd7, 1'b1, 0, 2, nW, doneAt, fA, lA);
    chk("pixCount", nW, 1); chk("pixAddr", fA, 19199); chk("pixDoneCycle", doneAt, 2);

    // One-column outline.
    runBox(8'd5, 8'd5, 7'd0, 7'd3, 3'd4, 1'b1, 0, 0, nW, doneAt, fA, lA);
    chk("colOutlineCount", nW, 4); chk("colOutlineDoneCycle", doneAt, 5);

    // Reset after 3 writes.
    @(posedge clk); #1;
    xLeft = 8'd0; xRight = 8'd9; yTop = 7'd0; yBottom = 7'd9; colIn = 3'd6; mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("rstRunWrEn", wrEn, 1);
      chk("rstRunX", xOut, c - 1);
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("midRstWrEn", wrEn, 0);   chk("midRstBusy", busy, 0);
    chk("midRstDone", done, 0);   chk("midRstErr", err, 0);
    chk("midRstX", xOut, 0);      chk("midRstY", yOut, 0);
    chk("midRstAddr", addrOut, 0); chk("midRstCol", colOut, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("postRstDone", done, 0);
      chk("postRstWrEn", wrEn, 0);
    end

    // Fresh start after reset.
    runBox(8'd1, 8'd3, 7'd1, 7'd2, 3'd3, 1'b0, 0, 0, nW, doneAt, fA, lA);
    chk("freshCount", nW, 6); chk("freshDoneCycle", doneAt, 7);

    // Random boxes with random backpressure; some fall off the screen or invert.
    for (int i = 0; i < 40; i++) begin
      a   = int'($urandom_range(0, 159));
      b   = int'($urandom_range(0, 119));
      rxl = 8'(a);
      rxr = 8'(a + int'($urandom_range(0, 9)) - 1);
      ryt = 7'(b);
      ryb = 7'(b + int'($urandom_range(0, 9)) - 1);
      runBox(rxl, rxr, ryt, ryb, 3'($urandom), 1'($urandom), 2, 0, nW, doneAt, fA, lA);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
